// File: rtl/sprite_write_master.sv
// Avalon-MM write initiator that flushes a dirty-tracked shadow table of sprite words once per frame.
// Optional write watchdog: define SPRITE_WRITE_MASTER_TIMEOUT_EN.
module sprite_write_master #(
  parameter int NUM_SPRITES = 30,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_index,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              frame_sync,
  input  logic              flush,
  output logic [ADDR_W-1:0] av_address,
  output logic [DATA_W-1:0] av_writedata,
  output logic              av_write,
  output logic              av_chipselect,
  input  logic              av_waitrequest,
  output logic              busy,
  output logic              sweep_done,
  output logic              err
);

  // Handshake: a transfer is presented with av_write=av_chipselect=1 and
  // address/data held constant; it completes in the first cycle in which
  // av_waitrequest=0, and the strobes drop on the following edge.

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SPRITES - 1);
  localparam logic [ADDR_W:0]   NUM_LIMIT = (ADDR_W + 1)'(NUM_SPRITES);

  state_t                  state;
  logic [DATA_W-1:0]       shadow [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  dirty;
  logic [ADDR_W-1:0]       ptr;
  logic                    pending;
  logic                    fs_q;
  logic                    fs_rise;
  logic                    reload;
  logic                    ld_ok;
  logic                    ld_hits_ptr;
  logic                    trigger;
  logic                    accept;
  logic                    abandon;

  assign ld_ok       = ld_we && ({1'b0, ld_index} < NUM_LIMIT);
  assign ld_hits_ptr = ld_ok && (ld_index == ptr);
  assign trigger     = fs_rise || flush;
  assign accept      = (state == WRITE) && !av_waitrequest;

  // Shadow table and dirty bits. A load in the same cycle as acceptance wins
  // because its assignment comes last, so the new word stays dirty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (accept && !reload) begin
        dirty[ptr] <= 1'b0;
      end
      if (ld_ok) begin
        shadow[ld_index] <= ld_data;
        dirty[ld_index]  <= 1'b1;
      end
    end
  end

  // Sweep sequencer. reload remembers a load to the entry in flight during
  // its earlier WRITE cycles, so that word is not lost when the old one lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      pending       <= 1'b0;
      fs_q          <= 1'b0;
      fs_rise       <= 1'b0;
      reload        <= 1'b0;
      av_address    <= '0;
      av_writedata  <= '0;
      av_write      <= 1'b0;
      av_chipselect <= 1'b0;
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      fs_q       <= frame_sync;
      fs_rise    <= frame_sync && !fs_q;
      sweep_done <= 1'b0;
      if (trigger && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger || pending) begin
            state   <= SCAN;
            ptr     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (dirty[ptr]) begin
            state         <= WRITE;
            av_address    <= ptr;
            av_writedata  <= shadow[ptr];
            av_write      <= 1'b1;
            av_chipselect <= 1'b1;
            reload        <= ld_hits_ptr;
          end else if (ptr == LAST_IDX) begin
            state      <= DONE;
            sweep_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        WRITE: begin
          if (accept || abandon) begin
            av_write      <= 1'b0;
            av_chipselect <= 1'b0;
            if (ptr == LAST_IDX) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              state <= SCAN;
              ptr   <= ptr + 1'b1;
            end
          end else if (ld_hits_ptr) begin
            reload <= 1'b1;
          end
        end
        DONE: begin
          ptr <= '0;
          // Chain straight into the queued sweep so busy never dips between sweeps.
          if (pending || trigger) begin
            state   <= SCAN;
            pending <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPRITE_WRITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] to_cnt;

  // The stalled cycle that would be number TIMEOUT gives up the transfer.
  assign abandon = (state == WRITE) && av_waitrequest && (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != WRITE) begin
        to_cnt <= '0;
      end else if (av_waitrequest) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (abandon) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign abandon = 1'b0;
  // TIMEOUT only matters when the watchdog is built in.
  assign err     = 1'b0 && (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_sprite_write_master.sv
// Directed plus randomized bench for sprite_write_master: a table/dirty model predicts each sweep's writes.
`timescale 1ns/1ps
module tb_sprite_write_master;

  localparam int NS = 30;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_index = '0;
  logic [DW-1:0] ld_data = '0;
  logic          frame_sync = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] av_address;
  logic [DW-1:0] av_writedata;
  logic          av_write;
  logic          av_chipselect;
  logic          av_waitrequest = 1'b0;
  logic          busy;
  logic          sweep_done;
  logic          err;

  sprite_write_master #(
    .NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ld_we(ld_we), .ld_index(ld_index),
    .ld_data(ld_data), .frame_sync(frame_sync), .flush(flush),
    .av_address(av_address), .av_writedata(av_writedata), .av_write(av_write),
    .av_chipselect(av_chipselect), .av_waitrequest(av_waitrequest),
    .busy(busy), .sweep_done(sweep_done), .err(err)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  // ---------------- reference model and scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_shadow [NS];
  bit            m_dirty [NS];

  int acc_count = 0;
  int acc_cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int run_len = 0;
  int last_run_len = 0;
  int first_wr_cyc = 0;
  int wr_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b0;
    end
  endtask

  // One sweep writes every dirty entry once, lowest index first.
  task automatic queue_sweep();
    for (int i = 0; i < NS; i++) begin
      if (m_dirty[i]) begin
        exp_q.push_back({AW'(i), m_shadow[i]});
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  // Bus monitor: every presented transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      check("cs_eq_write", {63'd0, av_chipselect}, {63'd0, av_write});
      if (av_write) begin
        if (run_len == 0) first_wr_cyc = cyc;
        run_len++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, av_address, av_writedata}, 64'd0);
        end else begin
          check("write_addr_data", {27'd0, av_address, av_writedata}, {27'd0, exp_q[0]});
        end
        if (!av_waitrequest) begin
          acc_count++;
          acc_cyc = cyc;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (run_len != 0) begin
        last_run_len = run_len;
        run_len = 0;
      end
      if (sweep_done) begin
        done_count++;
        done_cyc = cyc;
      end
    end else begin
      run_len = 0;
    end
  end

  // Random waitrequest source with stalls capped well under the watchdog limit.
  initial begin
    int stall_run;
    stall_run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_mode == 1) begin
        if (stall_run < 3 && $urandom_range(0, 2) == 0) begin
          av_waitrequest = 1'b1;
          stall_run++;
        end else begin
          av_waitrequest = 1'b0;
          stall_run = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [DW-1:0] data);
    tick();
    ld_we    = 1'b1;
    ld_index = AW'(idx);
    ld_data  = data;
    if (idx < NS) begin
      m_shadow[idx] = data;
      m_dirty[idx]  = 1'b1;
    end
    tick();
    ld_we = 1'b0;
  endtask

  task automatic pulse_flush(output int k);
    tick();
    flush = 1'b1;
    k = cyc;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sweep_done_count", 64'(done_count), 64'(target));
  endtask

  task automatic wait_write(input logic [AW-1:0] addr, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(av_write && av_address == addr) && n < budget);
    check("write_seen", {58'd0, av_write, av_address}, {58'd0, 1'b1, addr});
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int k, a0, d0, nexp, seen, busy_lo, n, nld;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_av_write", 64'(av_write), 64'd0);
    check("rst_av_cs", 64'(av_chipselect), 64'd0);
    check("rst_av_address", 64'(av_address), 64'd0);
    check("rst_av_writedata", 64'(av_writedata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sweep_done", 64'(sweep_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Two dirty entries written in index order, then an empty sweep
    load(3, 32'hDEADBEEF);
    load(29, 32'h12345678);
    queue_sweep();
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("two_writes", 64'(acc_count - a0), 64'd2);
    check("two_writes_drained", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
    check("single_done_pulse", 64'(done_count), 64'(d0 + 1));
    a0 = acc_count; d0 = done_count;
    queue_sweep();
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("empty_sweep_latency", 64'(done_cyc - k), 64'(NS + 1));
    check("empty_sweep_no_write", 64'(acc_count - a0), 64'd0);

    // Entry 0 held by waitrequest for five cycles
    load(0, 32'h000000A5);
    queue_sweep();
    av_waitrequest = 1'b1;
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    while (cyc < k + 7) tick();
    av_waitrequest = 1'b0;
    wait_done(d0 + 1, 200);
    check("stall_first_write_cycle", 64'(first_wr_cyc - k), 64'd2);
    check("stall_accept_cycle", 64'(acc_cyc - k), 64'd7);
    check("stall_write_len", 64'(last_run_len), 64'd6);
    a0 = acc_count; d0 = done_count;
    queue_sweep();
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("entry0_clean", 64'(acc_count - a0), 64'd0);

    // Load to the entry being accepted goes to the next sweep; out-of-range loads ignored
    av_waitrequest = 1'b1;
    load(7, 32'h00000011);
    queue_sweep();
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    wait_write(AW'(7), 50);
    tick();
    ld_we = 1'b1; ld_index = AW'(7); ld_data = 32'h77;
    m_shadow[7] = 32'h77; m_dirty[7] = 1'b1;
    av_waitrequest = 1'b0;
    tick();
    ld_we = 1'b0;
    load(31, 32'hBAD0BAD0);
    load(30, 32'hBAD1BAD1);
    wait_done(d0 + 1, 200);
    check("accept_reload_old", 64'(acc_count - a0), 64'd1);
    queue_sweep();
    check("reload_expected", 64'(exp_q.size()), 64'd1);
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("reload_written", 64'(acc_count - a0), 64'd1);
    check("reload_drained", 64'(exp_q.size()), 64'd0);

    // Triggers while busy collapse into one chained sweep
    load(1, 32'h101); load(10, 32'h110); load(20, 32'h120);
    queue_sweep();
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    tick(); frame_sync = 1'b1;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    tick(); frame_sync = 1'b0;
    seen = 0; busy_lo = 0; n = 0;
    while (seen < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (sweep_done) seen++;
      else if (!busy) busy_lo++;
    end
    check("chained_sweeps", 64'(seen), 64'd2);
    check("busy_continuous", 64'(busy_lo), 64'd0);
    check("chained_writes", 64'(acc_count - a0), 64'd3);
    repeat (40) tick();
    check("no_third_sweep", 64'(done_count), 64'(d0 + 2));
    check("idle_after_chain", 64'(busy), 64'd0);

    // Randomized loads, triggers and waitrequest
    for (int r = 0; r < 10; r++) begin
      nld = $urandom_range(1, 8);
      for (int j = 0; j < nld; j++) load($urandom_range(0, 31), $urandom);
      queue_sweep();
      nexp = exp_q.size();
      a0 = acc_count; d0 = done_count;
      wr_mode = r % 2;
      if (r % 3 == 0) begin
        tick(); frame_sync = 1'b1;
        tick(); tick(); frame_sync = 1'b0;
      end else begin
        pulse_flush(k);
      end
      wait_done(d0 + 1, 2000);
      check("rand_writes", 64'(acc_count - a0), 64'(nexp));
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      wr_mode = 0;
      tick();
      av_waitrequest = 1'b0;
    end

    // Reset in the middle of a stalled write
    av_waitrequest = 1'b1;
    load(5, 32'h55);
    queue_sweep();
    pulse_flush(k);
    wait_write(AW'(5), 50);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_av_write", 64'(av_write), 64'd0);
    check("midrst_av_cs", 64'(av_chipselect), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    model_reset();
    av_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    a0 = acc_count; d0 = done_count;
    queue_sweep();
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("midrst_dirty_cleared", 64'(acc_count - a0), 64'd0);
    check("midrst_sweep_latency", 64'(done_cyc - k), 64'(NS + 1));

`ifdef SPRITE_WRITE_MASTER_TIMEOUT_EN
    // Stuck waitrequest: abandoned after TO cycles, entry stays dirty, err sticks
    av_waitrequest = 1'b1;
    load(2, 32'h22);
    queue_sweep();
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("timeout_write_len", 64'(last_run_len), 64'(TO));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_no_accept", 64'(acc_count - a0), 64'd0);
    exp_q.delete();
    m_dirty[2] = 1'b1;
    av_waitrequest = 1'b0;
    queue_sweep();
    a0 = acc_count; d0 = done_count;
    pulse_flush(k);
    wait_done(d0 + 1, 200);
    check("timeout_retry_write", 64'(acc_count - a0), 64'd1);
    check("timeout_err_sticky", 64'(err), 64'd1);
`else
    check("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
